// File: rtl/y86_pkg.sv
// Shared Y86-64 definitions: opcodes, status codes, fetch FSM states and the
// registered fetch-result payload.
package y86_pkg;

  localparam int unsigned XLEN   = 64;
  localparam int unsigned STAT_W = 3;

  localparam logic [3:0] IHALT   = 4'h0;
  localparam logic [3:0] INOP    = 4'h1;
  localparam logic [3:0] IRRMOVQ = 4'h2;
  localparam logic [3:0] IIRMOVQ = 4'h3;
  localparam logic [3:0] IRMMOVQ = 4'h4;
  localparam logic [3:0] IMRMOVQ = 4'h5;
  localparam logic [3:0] IOPQ    = 4'h6;
  localparam logic [3:0] IJXX    = 4'h7;
  localparam logic [3:0] ICALL   = 4'h8;
  localparam logic [3:0] IRET    = 4'h9;
  localparam logic [3:0] IPUSHQ  = 4'hA;
  localparam logic [3:0] IPOPQ   = 4'hB;

  localparam logic [3:0] RNONE = 4'hF;

  localparam logic [STAT_W-1:0] STAT_AOK = 3'd1;
  localparam logic [STAT_W-1:0] STAT_HLT = 3'd2;
  localparam logic [STAT_W-1:0] STAT_ADR = 3'd3;
  localparam logic [STAT_W-1:0] STAT_INS = 3'd4;

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_DONE,
    S_HALT
  } fetch_state_t;

  typedef struct packed {
    logic [3:0]        icode;
    logic [3:0]        ifun;
    logic [3:0]        ra;
    logic [3:0]        rb;
    logic [XLEN-1:0]   valc;
    logic [XLEN-1:0]   valp;
    logic [STAT_W-1:0] stat;
  } fetch_result_t;

  localparam fetch_result_t RESULT_RESET = '{
    icode: 4'h0,
    ifun:  4'h0,
    ra:    RNONE,
    rb:    RNONE,
    valc:  '0,
    valp:  '0,
    stat:  STAT_AOK
  };

endpackage

// File: rtl/y86_instr_len.sv
// Combinational instruction-format lookup: byte length, register byte,
// constant word and legality of the icode/ifun pair.
module y86_instr_len
  import y86_pkg::*;
(
  input  logic [3:0] icode,
  input  logic [3:0] ifun,
  output logic [3:0] len,
  output logic       need_regs,
  output logic       need_valc,
  output logic       valid
);

  always_comb begin
    len       = 4'd1;
    need_regs = 1'b0;
    need_valc = 1'b0;
    valid     = 1'b0;
    case (icode)
      IHALT, INOP, IRET: begin
        valid = (ifun == 4'h0);
      end
      IRRMOVQ: begin
        len       = 4'd2;
        need_regs = 1'b1;
        valid     = (ifun <= 4'h6);
      end
      IOPQ: begin
        len       = 4'd2;
        need_regs = 1'b1;
        valid     = (ifun <= 4'h3);
      end
      IPUSHQ, IPOPQ: begin
        len       = 4'd2;
        need_regs = 1'b1;
        valid     = (ifun == 4'h0);
      end
      IJXX: begin
        len       = 4'd9;
        need_valc = 1'b1;
        valid     = (ifun <= 4'h6);
      end
      ICALL: begin
        len       = 4'd9;
        need_valc = 1'b1;
        valid     = (ifun == 4'h0);
      end
      IIRMOVQ, IRMMOVQ, IMRMOVQ: begin
        len       = 4'd10;
        need_regs = 1'b1;
        need_valc = 1'b1;
        valid     = (ifun == 4'h0);
      end
      default: begin
        valid = 1'b0;
      end
    endcase
    // Illegal encodings are fetched as a single byte.
    if (!valid) begin
      len       = 4'd1;
      need_regs = 1'b0;
      need_valc = 1'b0;
    end
  end

endmodule

// File: rtl/y86_fetch_unit.sv
// Multi-cycle Y86-64 fetch stage: reads one instruction byte per cycle from a
// 1-cycle-latency byte memory and presents decoded fields over valid/ready.
module y86_fetch_unit
  import y86_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  input  logic [XLEN-1:0] in_pc,
  output logic            in_ready,
  output logic            imem_rd,
  output logic [XLEN-1:0] imem_addr,
  input  logic [7:0]      imem_rdata,
  input  logic            imem_err,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      icode,
  output logic [3:0]      ifun,
  output logic [3:0]      rA,
  output logic [3:0]      rB,
  output logic [XLEN-1:0] valC,
  output logic [XLEN-1:0] valP,
  output logic [2:0]      stat
);

  fetch_state_t    state_q, state_d;
  logic [XLEN-1:0] base_q, base_d;
  logic [3:0]      idx_q, idx_d;
  logic            pend_q, pend_d;
  logic [3:0]      len_q, len_d;
  logic            regs_q, regs_d;
  logic            valc_q, valc_d;
  fetch_result_t   res_q, res_d;
  logic            in_ready_q;

  logic            rd_c;
  logic [3:0]      issue_idx;
  logic [2:0]      valc_idx;
  logic [3:0]      len_c;
  logic            need_regs_c;
  logic            need_valc_c;
  logic            valid_c;

  y86_instr_len u_len (
    .icode     (imem_rdata[7:4]),
    .ifun      (imem_rdata[3:0]),
    .len       (len_c),
    .need_regs (need_regs_c),
    .need_valc (need_valc_c),
    .valid     (valid_c)
  );

  // Byte position inside valC for the byte arriving this cycle.
  assign valc_idx = 3'(idx_q - (regs_q ? 4'd2 : 4'd1));

  // Next-state, result assembly and read issue. pend_q marks a byte returning
  // this cycle; its index is idx_q. The next byte is issued in the same cycle.
  always_comb begin
    state_d   = state_q;
    base_d    = base_q;
    idx_d     = idx_q;
    pend_d    = pend_q;
    len_d     = len_q;
    regs_d    = regs_q;
    valc_d    = valc_q;
    res_d     = res_q;
    rd_c      = 1'b0;
    issue_idx = 4'd0;
    case (state_q)
      S_IDLE: begin
        if (in_valid && in_ready_q) begin
          base_d  = in_pc;
          idx_d   = 4'd0;
          pend_d  = 1'b0;
          res_d   = RESULT_RESET;
          state_d = S_FETCH;
        end
      end
      S_FETCH: begin
        if (!pend_q) begin
          rd_c      = 1'b1;
          issue_idx = 4'd0;
          pend_d    = 1'b1;
        end else if (imem_err) begin
          res_d.stat = STAT_ADR;
          res_d.valp = base_q + XLEN'(idx_q);
          pend_d     = 1'b0;
          state_d    = S_DONE;
        end else if (idx_q == 4'd0) begin
          res_d.icode = imem_rdata[7:4];
          res_d.ifun  = imem_rdata[3:0];
          len_d       = len_c;
          regs_d      = need_regs_c;
          valc_d      = need_valc_c;
          if (!valid_c) begin
            res_d.stat = STAT_INS;
            res_d.valp = base_q + XLEN'(1);
            pend_d     = 1'b0;
            state_d    = S_DONE;
          end else if (len_c == 4'd1) begin
            res_d.stat = (imem_rdata[7:4] == IHALT) ? STAT_HLT : STAT_AOK;
            res_d.valp = base_q + XLEN'(1);
            pend_d     = 1'b0;
            state_d    = S_DONE;
          end else begin
            rd_c      = 1'b1;
            issue_idx = 4'd1;
            idx_d     = 4'd1;
          end
        end else begin
          if (regs_q && idx_q == 4'd1) begin
            res_d.ra = imem_rdata[7:4];
            res_d.rb = imem_rdata[3:0];
          end else if (valc_q) begin
            res_d.valc[{valc_idx, 3'b000} +: 8] = imem_rdata;
          end
          if (idx_q == 4'(len_q - 4'd1)) begin
            res_d.stat = STAT_AOK;
            res_d.valp = base_q + XLEN'(len_q);
            pend_d     = 1'b0;
            state_d    = S_DONE;
          end else begin
            rd_c      = 1'b1;
            issue_idx = 4'(idx_q + 4'd1);
            idx_d     = 4'(idx_q + 4'd1);
          end
        end
      end
      S_DONE: begin
        if (out_ready) begin
          state_d = (res_q.stat == STAT_AOK) ? S_IDLE : S_HALT;
        end
      end
      S_HALT: begin
        state_d = S_HALT;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      base_q     <= '0;
      idx_q      <= 4'd0;
      pend_q     <= 1'b0;
      len_q      <= 4'd1;
      regs_q     <= 1'b0;
      valc_q     <= 1'b0;
      res_q      <= RESULT_RESET;
      in_ready_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      base_q     <= base_d;
      idx_q      <= idx_d;
      pend_q     <= pend_d;
      len_q      <= len_d;
      regs_q     <= regs_d;
      valc_q     <= valc_d;
      res_q      <= res_d;
      in_ready_q <= (state_d == S_IDLE);
    end
  end

  // The read strobe must react to byte 0 and imem_err in the same cycle.
  assign imem_rd   = rd_c;
  assign imem_addr = rd_c ? (base_q + XLEN'(issue_idx)) : '0;
  assign in_ready  = in_ready_q;
  assign out_valid = (state_q == S_DONE);
  assign icode     = res_q.icode;
  assign ifun      = res_q.ifun;
  assign rA        = res_q.ra;
  assign rB        = res_q.rb;
  assign valC      = res_q.valc;
  assign valP      = res_q.valp;
  assign stat      = res_q.stat;

endmodule

// File: tb/tb_y86_fetch_unit.sv
// Self-checking bench for y86_fetch_unit: directed scenarios plus randomized
// instructions checked against a byte-level reference model of the ISA rules.
module tb_y86_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [63:0] in_pc = '0;
  logic        in_ready;
  logic        imem_rd;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata = 8'h00;
  logic        imem_err = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [3:0]  icode, ifun, rA, rB;
  logic [63:0] valC, valP;
  logic [2:0]  stat;

  always #5 clk = ~clk;

  y86_fetch_unit u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_pc(in_pc), .in_ready(in_ready),
    .imem_rd(imem_rd), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_err(imem_err),
    .out_valid(out_valid), .out_ready(out_ready), .icode(icode), .ifun(ifun),
    .rA(rA), .rB(rB), .valC(valC), .valP(valP), .stat(stat)
  );

  typedef struct packed {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [2:0]  stat;
  } res_t;

  localparam res_t RES_RST = {4'h0, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0, 3'd1};

  int tests = 0;
  int fails = 0;
  int cyc = 0;

  logic [7:0]  mem [logic [63:0]];
  bit          err_at [logic [63:0]];
  logic [63:0] rd_addr_q [$];
  int          rd_cyc_q [$];

  // Byte memory: data and error flag appear the cycle after a sampled read.
  always @(posedge clk) begin
    cyc        <= cyc + 1;
    imem_err   <= 1'b0;
    imem_rdata <= 8'($urandom);
    if (imem_rd) begin
      rd_addr_q.push_back(imem_addr);
      rd_cyc_q.push_back(cyc);
      imem_rdata <= mem.exists(imem_addr) ? mem[imem_addr] : 8'($urandom);
      imem_err   <= err_at.exists(imem_addr);
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic res_t sample();
    return {icode, ifun, rA, rB, valC, valP, stat};
  endfunction

  // Instruction length from the ISA table; 0 marks an illegal encoding.
  function automatic int ilen(input logic [7:0] b);
    logic [3:0] ic;
    logic [3:0] fn;
    ic = b[7:4];
    fn = b[3:0];
    case (ic)
      4'h0, 4'h1, 4'h9: return (fn == 4'h0) ? 1 : 0;
      4'h2:             return (fn <= 4'h6) ? 2 : 0;
      4'h6:             return (fn <= 4'h3) ? 2 : 0;
      4'hA, 4'hB:       return (fn == 4'h0) ? 2 : 0;
      4'h7:             return (fn <= 4'h6) ? 9 : 0;
      4'h8:             return (fn == 4'h0) ? 9 : 0;
      4'h3, 4'h4, 4'h5: return (fn == 4'h0) ? 10 : 0;
      default:          return 0;
    endcase
  endfunction

  function automatic void model(input logic [63:0] base, output res_t e, output int nrd);
    int n;
    int off;
    logic [63:0] a;
    logic [7:0] b;
    e   = RES_RST;
    nrd = 0;
    n   = 1;
    off = 1;
    for (int k = 0; k < n; k++) begin
      a = base + 64'(k);
      nrd++;
      if (err_at.exists(a)) begin
        e.stat = 3'd3;
        e.valp = a;
        return;
      end
      b = mem[a];
      if (k == 0) begin
        e.icode = b[7:4];
        e.ifun  = b[3:0];
        n = ilen(b);
        if (n == 0) begin
          e.stat = 3'd4;
          e.valp = base + 64'd1;
          return;
        end
        off = (n == 10) ? 2 : 1;
      end else if ((n == 2 || n == 10) && k == 1) begin
        e.ra = b[7:4];
        e.rb = b[3:0];
      end else begin
        e.valc[8*(k-off) +: 8] = b;
      end
    end
    e.stat = (e.icode == 4'h0) ? 3'd2 : 3'd1;
    e.valp = base + 64'(n);
  endfunction

  // Captured by run_fetch for the calling test to judge.
  res_t obs;
  int   lat;
  int   nrd_obs;
  bit   seq_ok;
  bit   stall_ok;
  bit   ready_after;

  task automatic load(input logic [63:0] base, input logic [7:0] bytes [$]);
    foreach (bytes[k]) mem[base + 64'(k)] = bytes[k];
  endtask

  task automatic clear_mem();
    mem.delete();
    err_at.delete();
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  // One request/response; hold = cycles out_ready stays low in DONE.
  task automatic run_fetch(input logic [63:0] base, input int hold);
    int t;
    int acc;
    int e;
    bit seen;
    t = 0;
    while (!in_ready && t < 20) begin @(posedge clk); #1; t++; end
    rd_addr_q.delete();
    rd_cyc_q.delete();
    in_valid = 1'b1;
    in_pc = base;
    @(posedge clk); acc = cyc; #1;
    // Keep in_valid asserted with garbage PCs; it must be ignored while busy.
    in_pc = {$urandom, $urandom};
    seen = 1'b0;
    lat = -1;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(posedge clk); e = cyc; #1;
      if (out_valid) begin seen = 1'b1; lat = e - acc; end
    end
    in_valid = 1'b0;
    tests++;
    if (!seen) begin
      fails++;
      $display("FAIL done_timeout: out_valid=%0b after 40 cycles, want 1", out_valid);
    end
    obs = sample();
    nrd_obs = rd_addr_q.size();
    seq_ok = 1'b1;
    foreach (rd_addr_q[k])
      if (rd_addr_q[k] !== base + 64'(k) || rd_cyc_q[k] != acc + 1 + k) seq_ok = 1'b0;
    stall_ok = !imem_rd && !in_ready;
    repeat (hold) begin
      @(posedge clk); #1;
      if (sample() !== obs || !out_valid || in_ready || imem_rd) stall_ok = 1'b0;
    end
    if (rd_addr_q.size() != nrd_obs) stall_ok = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    ready_after = in_ready;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || imem_rd !== 1'b0 || imem_addr !== 64'h0) begin
      fails++;
      $display("FAIL reset_strobes: in_ready=%b out_valid=%b imem_rd=%b addr=%h, want 0 0 0 0",
               in_ready, out_valid, imem_rd, imem_addr);
    end
    tests++;
    if (sample() !== RES_RST) begin
      fails++;
      $display("FAIL reset_fields: got %h want %h", sample(), RES_RST);
    end
    rst = 1'b0;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_nop();
    clear_mem();
    load(64'h100, '{8'h10});
    run_fetch(64'h100, 0);
    tests++;
    if (nrd_obs != 1 || !seq_ok) begin
      fails++;
      $display("FAIL nop_reads: got %0d reads seq_ok=%b, want 1 read at 0x100", nrd_obs, seq_ok);
    end
    tests++;
    if (lat != 2) begin
      fails++;
      $display("FAIL nop_latency: got %0d want 2 cycles after accept edge", lat);
    end
    tests++;
    if (obs !== {4'h1, 4'h0, 4'hF, 4'hF, 64'h0, 64'h101, 3'd1}) begin
      fails++;
      $display("FAIL nop_fields: got %h", obs);
    end
    tests++;
    if (ready_after !== 1'b1) begin
      fails++;
      $display("FAIL nop_ready_after: got %b want 1", ready_after);
    end
  endtask

  task automatic test_irmovq();
    clear_mem();
    load(64'h0, '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    run_fetch(64'h0, 0);
    tests++;
    if (nrd_obs != 10 || !seq_ok) begin
      fails++;
      $display("FAIL irmovq_reads: got %0d reads seq_ok=%b, want 10 at 0x0-0x9", nrd_obs, seq_ok);
    end
    tests++;
    if (lat != 11) begin
      fails++;
      $display("FAIL irmovq_latency: got %0d want 11", lat);
    end
    tests++;
    if (obs !== {4'h3, 4'h0, 4'hF, 4'h3, 64'h0102030405060708, 64'hA, 3'd1}) begin
      fails++;
      $display("FAIL irmovq_fields: got %h", obs);
    end
  endtask

  task automatic test_stall();
    clear_mem();
    load(64'h200, '{8'h60, 8'h12});
    run_fetch(64'h200, 5);
    tests++;
    if (!stall_ok) begin
      fails++;
      $display("FAIL stall_hold: stable=%b, want outputs frozen with in_ready=0 and no reads", stall_ok);
    end
    tests++;
    if (obs !== {4'h6, 4'h0, 4'h1, 4'h2, 64'h0, 64'h202, 3'd1}) begin
      fails++;
      $display("FAIL stall_fields: got %h", obs);
    end
  endtask

  task automatic test_wrap();
    logic [63:0] base;
    base = 64'hFFFF_FFFF_FFFF_FFFC;
    clear_mem();
    load(base, '{8'h70, 8'hEF, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01});
    run_fetch(base, 1);
    tests++;
    if (nrd_obs != 9 || !seq_ok || rd_addr_q[8] !== 64'h4) begin
      fails++;
      $display("FAIL wrap_reads: got %0d reads seq_ok=%b, want 9 wrapping to 0x4", nrd_obs, seq_ok);
    end
    tests++;
    if (obs !== {4'h7, 4'h0, 4'hF, 4'hF, 64'h0123456789ABCDEF, 64'h5, 3'd1}) begin
      fails++;
      $display("FAIL wrap_fields: got %h", obs);
    end
  endtask

  task automatic test_ins_halt();
    res_t held;
    clear_mem();
    load(64'h400, '{8'hE0, 8'h11, 8'h22});
    run_fetch(64'h400, 0);
    tests++;
    if (nrd_obs != 1 || lat != 2) begin
      fails++;
      $display("FAIL ins_reads: got %0d reads lat %0d, want 1 read lat 2", nrd_obs, lat);
    end
    tests++;
    if (obs !== {4'hE, 4'h0, 4'hF, 4'hF, 64'h0, 64'h401, 3'd4}) begin
      fails++;
      $display("FAIL ins_fields: got %h", obs);
    end
    held = sample();
    in_valid = 1'b1;
    in_pc = 64'h100;
    repeat (4) @(posedge clk);
    #1;
    in_valid = 1'b0;
    tests++;
    if (ready_after !== 1'b0 || in_ready !== 1'b0 || rd_addr_q.size() != 1 || sample() !== held) begin
      fails++;
      $display("FAIL halt_frozen: in_ready=%b reads=%0d fields=%h, want 0 1 %h",
               in_ready, rd_addr_q.size(), sample(), held);
    end
    apply_reset();
    tests++;
    if (in_ready !== 1'b1) begin
      fails++;
      $display("FAIL halt_reset_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_adr_call();
    clear_mem();
    load(64'h800, '{8'h80, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88});
    err_at[64'h803] = 1'b1;
    run_fetch(64'h800, 2);
    tests++;
    if (nrd_obs != 4 || !seq_ok || lat != 5) begin
      fails++;
      $display("FAIL adr_reads: got %0d reads seq_ok=%b lat %0d, want 4 reads lat 5", nrd_obs, seq_ok, lat);
    end
    tests++;
    if (obs !== {4'h8, 4'h0, 4'hF, 4'hF, 64'h2211, 64'h803, 3'd3}) begin
      fails++;
      $display("FAIL adr_fields: got %h", obs);
    end
    tests++;
    if (ready_after !== 1'b0) begin
      fails++;
      $display("FAIL adr_halt: in_ready got %b want 0", ready_after);
    end
    apply_reset();
  endtask

  task automatic test_reset_mid_fetch();
    clear_mem();
    load(64'h2000, '{8'h30, 8'hF3, 8'h08, 8'h07, 8'h06, 8'h05, 8'h04, 8'h03, 8'h02, 8'h01});
    in_valid = 1'b1;
    in_pc = 64'h2000;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    tests++;
    if (imem_rd !== 1'b1) begin
      fails++;
      $display("FAIL midfetch_busy: imem_rd got %b want 1", imem_rd);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    tests++;
    if (in_ready !== 1'b0 || out_valid !== 1'b0 || imem_rd !== 1'b0 || imem_addr !== 64'h0 ||
        sample() !== RES_RST) begin
      fails++;
      $display("FAIL midfetch_reset: in_ready=%b out_valid=%b imem_rd=%b fields=%h",
               in_ready, out_valid, imem_rd, sample());
    end
    rst = 1'b0;
    @(posedge clk); #1;
    load(64'h300, '{8'h90});
    run_fetch(64'h300, 0);
    tests++;
    if (obs !== {4'h9, 4'h0, 4'hF, 4'hF, 64'h0, 64'h301, 3'd1} || lat != 2 || nrd_obs != 1) begin
      fails++;
      $display("FAIL midfetch_recover: got %h lat %0d reads %0d", obs, lat, nrd_obs);
    end
  endtask

  task automatic test_random();
    res_t        exp;
    int          nrd;
    logic [63:0] base;
    logic [3:0]  ic;
    logic [3:0]  fn;
    int          fmax;
    for (int it = 0; it < 40; it++) begin
      clear_mem();
      base = ($urandom_range(0, 3) == 0) ? (64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7)))
                                         : {$urandom, $urandom};
      ic = 4'($urandom_range(0, 15));
      fmax = (ic == 4'h2 || ic == 4'h7) ? 6 : (ic == 4'h6) ? 3 : 0;
      fn = ($urandom_range(0, 9) < 7) ? 4'($urandom_range(0, fmax)) : 4'($urandom_range(0, 15));
      mem[base] = {ic, fn};
      for (int k = 1; k < 10; k++) mem[base + 64'(k)] = 8'($urandom);
      if ($urandom_range(0, 3) == 0) err_at[base + 64'($urandom_range(0, 9))] = 1'b1;
      model(base, exp, nrd);
      run_fetch(base, $urandom_range(0, 3));
      tests++;
      if (obs !== exp) begin
        fails++;
        $display("FAIL rand_fields[%0d]: got %h want %h", it, obs, exp);
      end
      tests++;
      if (nrd_obs != nrd || !seq_ok || lat != nrd + 1) begin
        fails++;
        $display("FAIL rand_timing[%0d]: reads %0d seq_ok=%b lat %0d, want %0d reads lat %0d",
                 it, nrd_obs, seq_ok, lat, nrd, nrd + 1);
      end
      tests++;
      if (!stall_ok || ready_after !== (exp.stat == 3'd1)) begin
        fails++;
        $display("FAIL rand_handshake[%0d]: stall_ok=%b in_ready=%b, want 1 %b",
                 it, stall_ok, ready_after, exp.stat == 3'd1);
      end
      if (exp.stat != 3'd1) apply_reset();
    end
  endtask

  initial begin
    test_reset();
    test_nop();
    test_irmovq();
    test_stall();
    test_wrap();
    test_ins_halt();
    test_adr_call();
    test_reset_mid_fetch();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
